uart_echo_responder: RTL and testbench

Far-end responder for the UART link. It accepts bytes delivered by a UART receiver (one-cycle valid strobe plus byte), buffers them in a small FIFO, and replays each byte, optionally XOR-masked, through a UART transmitter's byte-level handshake. It sits between the receive-side and transmit-side byte interfaces of the UART pair. It gives the link a loopback peer for system bring-up and regression, with no software in the loop.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_echo_responder_if.sv | 31 +++
 rtl/uart_byte_fifo.sv | 54 +++++
 rtl/uart_echo_responder.sv | 79 +++++++
 tb/tb_uart_echo_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo responder and its benches.
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int CLKS_PER_BIT = 217;

    // Echo FSM states; the encoding is also visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

endpackage

// File: rtl/uart_echo_responder_if.sv
// Byte-level links between the UART receiver, the echo responder and the
// UART transmitter.
//
// Handshake: the receive side is a strobe-only link. i_RX_DV is high for one
// cycle and i_RX_Byte is valid only in that cycle; there is no back-pressure,
// so a byte the responder cannot store is dropped. The transmit side is a
// launch/complete pair. o_TX_DV is high for one cycle to start a frame, and
// o_TX_Byte stays stable from that cycle until the cycle where i_TX_Done
// pulses. i_TX_Active is status only.
interface uart_echo_responder_if;
    import uart_pkg::*;

    logic                   i_RX_DV;
    logic [UART_BYTE_W-1:0] i_RX_Byte;
    logic                   o_TX_DV;
    logic [UART_BYTE_W-1:0] o_TX_Byte;
    logic                   i_TX_Active;
    logic                   i_TX_Done;

    // Responder side.
    modport slave (
        input  i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done,
        output o_TX_DV, o_TX_Byte
    );

    // Link side: the receiver/transmitter pair or a bench.
    modport master (
        output i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done,
        input  o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with a separately kept occupancy count, so full and empty are
// never ambiguous. A push while full is accepted only when a pop happens in
// the same cycle.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_L,
    input  logic                   i_Push,
    input  logic                   i_Pop,
    input  logic [UART_BYTE_W-1:0] i_Data,
    output logic [UART_BYTE_W-1:0] o_Data,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Full,
    output logic                   o_Empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign o_Full  = (o_Count == (PTR_W + 1)'(DEPTH));
    assign o_Empty = (o_Count == '0);
    assign do_pop  = i_Pop && !o_Empty;
    assign do_push = i_Push && (!o_Full || do_pop);
    assign o_Data  = mem[rd_ptr];

    // Pointers wrap modulo DEPTH; the count tracks occupancy on its own.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   o_Count <= o_Count + 1'b1;
                2'b01:   o_Count <= o_Count - 1'b1;
                default: o_Count <= o_Count;
            endcase
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge i_Clock) begin
        if (do_push) mem[wr_ptr] <= i_Data;
    end
endmodule

// File: rtl/uart_echo_responder.sv
// Loopback peer for the UART link: buffers received bytes and replays each
// one, XOR-masked with ECHO_MASK, through the transmitter's launch/done
// handshake. All outputs are registered.
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int                     DEPTH     = 8,
    parameter logic [UART_BYTE_W-1:0] ECHO_MASK = 8'h00
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_L,
    uart_echo_responder_if.slave      bus,
    input  logic                      i_Clear_Overflow,
    output logic [$clog2(DEPTH):0]    o_Count,
    output logic                      o_Overflow,
    output state_t                    o_State
);
    state_t                 state;
    logic                   tx_dv;
    logic [UART_BYTE_W-1:0] tx_byte;
    logic [UART_BYTE_W-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   overflow_set;

    // Transmitter busy is informational only; the done strobe paces echoes.
    wire unused_tx_active = bus.i_TX_Active;

    assign pop          = (state == IDLE) && !fifo_empty;
    assign overflow_set = bus.i_RX_DV && fifo_full && !pop;

    assign bus.o_TX_DV   = tx_dv;
    assign bus.o_TX_Byte = tx_byte;
    assign o_State       = state;

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .i_Push  (bus.i_RX_DV),
        .i_Pop   (pop),
        .i_Data  (bus.i_RX_Byte),
        .o_Data  (head),
        .o_Count (o_Count),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty)
    );

    // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L)              o_Overflow <= 1'b0;
        else if (overflow_set)     o_Overflow <= 1'b1;
        else if (i_Clear_Overflow) o_Overflow <= 1'b0;
    end

    // Echo sequencer: pop, one-cycle launch, wait for done, one idle gap.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        tx_byte <= head ^ ECHO_MASK;
                        tx_dv   <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH:    state <= WAIT_DONE;
                WAIT_DONE: if (bus.i_TX_Done) state <= GAP;
                GAP:       state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: one instance with a pure echo and
// one with an all-ones mask, both DEPTH=8.
module tb_uart_echo_responder;
    import uart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clr0;
    logic       clr1;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic       ovf0;
    logic       ovf1;
    state_t     st0;
    state_t     st1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    uart_echo_responder_if if0 ();
    uart_echo_responder_if if1 ();

    uart_echo_responder #(.DEPTH(8), .ECHO_MASK(8'h00)) dut0 (
        .i_Clock          (clk),
        .i_Rst_L          (rst_n),
        .bus              (if0.slave),
        .i_Clear_Overflow (clr0),
        .o_Count          (cnt0),
        .o_Overflow       (ovf0),
        .o_State          (st0)
    );

    uart_echo_responder #(.DEPTH(8), .ECHO_MASK(8'hFF)) dut1 (
        .i_Clock          (clk),
        .i_Rst_L          (rst_n),
        .bus              (if1.slave),
        .i_Clear_Overflow (clr1),
        .o_Count          (cnt1),
        .o_Overflow       (ovf1),
        .o_State          (st1)
    );

    // Clock and run-time guard.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // Driver helpers: inputs change 1 time unit after the rising edge, and
    // outputs are sampled at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   lat;
        logic seen_dv;
        logic [7:0] exp_b;

        rst_n = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        if0.i_RX_DV = 1'b0; if0.i_RX_Byte = 8'h00; if0.i_TX_Active = 1'b0; if0.i_TX_Done = 1'b0;
        if1.i_RX_DV = 1'b0; if1.i_RX_Byte = 8'h00; if1.i_TX_Active = 1'b0; if1.i_TX_Done = 1'b0;

        // Reset state.
        tick(); tick();
        check("rst_tx_dv", if0.o_TX_DV, 0);
        check("rst_tx_byte", if0.o_TX_Byte, 8'h00);
        check("rst_count", cnt0, 0);
        check("rst_overflow", ovf0, 0);
        check("rst_state", st0, IDLE);
        rst_n = 1'b1;
        tick();

        // Single echo of 3F: count 1 next cycle, launch the cycle after.
        if0.i_RX_DV = 1'b1; if0.i_RX_Byte = 8'h3F;
        tick();
        if0.i_RX_DV = 1'b0;
        check("echo_count_n1", cnt0, 1);
        check("echo_dv_n1", if0.o_TX_DV, 0);
        tick();
        check("echo_dv_n2", if0.o_TX_DV, 1);
        check("echo_byte_n2", if0.o_TX_Byte, 8'h3F);
        check("echo_count_n2", cnt0, 0);
        tick();
        check("echo_dv_single_cycle", if0.o_TX_DV, 0);
        check("echo_state_wait", st0, WAIT_DONE);
        tick(); tick();
        check("echo_hold_byte", if0.o_TX_Byte, 8'h3F);
        check("echo_hold_state", st0, WAIT_DONE);
        if0.i_TX_Done = 1'b1;
        tick();
        if0.i_TX_Done = 1'b0;
        check("echo_state_gap", st0, GAP);
        tick();
        check("echo_state_idle", st0, IDLE);

        // Masked echo on the second instance: A5 ^ FF = 5A.
        if1.i_RX_DV = 1'b1; if1.i_RX_Byte = 8'hA5;
        tick();
        if1.i_RX_DV = 1'b0;
        tick();
        check("mask_dv", if1.o_TX_DV, 1);
        check("mask_byte", if1.o_TX_Byte, 8'h5A);

        // Stray done while idle is ignored.
        if0.i_TX_Done = 1'b1;
        tick();
        if0.i_TX_Done = 1'b0;
        check("stray_state", st0, IDLE);
        check("stray_dv", if0.o_TX_DV, 0);
        tick();
        check("stray_state_after", st0, IDLE);
        check("stray_dv_after", if0.o_TX_DV, 0);

        // Burst of 00..09 with the transmitter stalled: 00 in flight,
        // 01..08 stored, 09 dropped.
        for (int k = 0; k < 10; k++) begin
            if0.i_RX_DV = 1'b1; if0.i_RX_Byte = 8'(k);
            if (k < 9) exp_q.push_back(8'(k));
            tick();
        end
        if0.i_RX_DV = 1'b0;
        check("burst_count", cnt0, 8);
        check("burst_overflow", ovf0, 1);
        check("burst_state", st0, WAIT_DONE);
        exp_b = exp_q.pop_front();
        check("burst_inflight_byte", if0.o_TX_Byte, exp_b);

        // Clear alone, then drop plus clear in one cycle: the drop wins.
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        check("clear_overflow", ovf0, 0);
        if0.i_RX_DV = 1'b1; if0.i_RX_Byte = 8'h77; clr0 = 1'b1;
        tick();
        if0.i_RX_DV = 1'b0; clr0 = 1'b0;
        check("set_beats_clear", ovf0, 1);
        check("drop_count", cnt0, 8);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        check("clear_again", ovf0, 0);

        // Push while full in the same cycle as the IDLE pop is accepted.
        if0.i_TX_Done = 1'b1;
        tick();
        if0.i_TX_Done = 1'b0;
        tick();
        check("full_idle_state", st0, IDLE);
        check("full_idle_count", cnt0, 8);
        if0.i_RX_DV = 1'b1; if0.i_RX_Byte = 8'h55;
        exp_q.push_back(8'h55);
        tick();
        if0.i_RX_DV = 1'b0;
        check("pushpop_count", cnt0, 8);
        check("pushpop_overflow", ovf0, 0);
        check("pushpop_dv", if0.o_TX_DV, 1);
        exp_b = exp_q.pop_front();
        check("pushpop_byte", if0.o_TX_Byte, exp_b);
        tick();

        // Drain the rest in order; each launch comes 3 cycles after done.
        for (int i = 0; i < 8; i++) begin
            if0.i_TX_Done = 1'b1;
            tick();
            if0.i_TX_Done = 1'b0;
            lat = 1;
            while (!if0.o_TX_DV && lat < 10) begin
                tick();
                lat++;
            end
            check("drain_latency", lat, 3);
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("drain_byte", if0.o_TX_Byte, exp_b);
            tick();
        end
        check("drain_count", cnt0, 0);
        if0.i_TX_Done = 1'b1;
        tick();
        if0.i_TX_Done = 1'b0;
        tick(); tick();
        check("drain_final_state", st0, IDLE);
        check("drain_final_dv", if0.o_TX_DV, 0);

        // Reset during WAIT_DONE with 3 bytes queued.
        if0.i_RX_DV = 1'b1; if0.i_RX_Byte = 8'h11; tick();
        if0.i_RX_Byte = 8'h22; tick();
        if0.i_RX_Byte = 8'h33; tick();
        if0.i_RX_Byte = 8'h44; tick();
        if0.i_RX_DV = 1'b0;
        check("midrst_pre_count", cnt0, 3);
        check("midrst_pre_state", st0, WAIT_DONE);
        rst_n = 1'b0;
        #1;
        check("midrst_count", cnt0, 0);
        check("midrst_dv", if0.o_TX_DV, 0);
        check("midrst_state", st0, IDLE);
        check("midrst_byte", if0.o_TX_Byte, 8'h00);
        tick();
        rst_n = 1'b1;
        seen_dv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if0.o_TX_DV !== 1'b0 || cnt0 !== 4'd0) seen_dv = 1'b1;
        end
        check("postrst_quiet", seen_dv, 0);
        if0.i_RX_DV = 1'b1; if0.i_RX_Byte = 8'h66;
        tick();
        if0.i_RX_DV = 1'b0;
        tick();
        check("postrst_dv", if0.o_TX_DV, 1);
        check("postrst_byte", if0.o_TX_Byte, 8'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
